// File: rtl/operand_fetch_stage_if.sv
// Decode-side and execute-side valid/ready bundles for operand_fetch_stage.
// master = upstream decode plus downstream execute; slave = the stage itself.
interface operand_fetch_stage_if #(
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs_a;
  logic [4:0]        in_rs_b;
  logic              in_use_a;
  logic              in_use_b;
  logic [4:0]        in_rd;
  logic              in_rd_we;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_a;
  logic [31:0]       out_b;
  logic [4:0]        out_rd;
  logic              out_rd_we;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_rs_a, in_rs_b,
    output in_use_a, in_use_b,
    output in_rd, in_rd_we, in_ctrl,
    input  in_ready,
    input  out_valid, out_a, out_b,
    input  out_rd, out_rd_we, out_ctrl,
    output out_ready
  );

  modport slave (
    input  in_valid, in_rs_a, in_rs_b,
    input  in_use_a, in_use_b,
    input  in_rd, in_rd_we, in_ctrl,
    output in_ready,
    output out_valid, out_a, out_b,
    output out_rd, out_rd_we, out_ctrl,
    input  out_ready
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: RF read, write-back bypass, $0 forcing,
// in-flight writer scoreboard and a valid/ready output register.
module operand_fetch_stage #(
  parameter int CTRL_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  operand_fetch_stage_if.slave bus,
  output logic [4:0]  rf_sel_a,
  output logic [4:0]  rf_sel_b,
  input  logic [31:0] rf_data_a,
  input  logic [31:0] rf_data_b,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic [31:0] busy_map
);

  logic [31:0]       busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_a_q, out_a_d;
  logic [31:0]       out_b_q, out_b_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              out_rd_we_q, out_rd_we_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;

  logic [31:0] opnd_a, opnd_b;
  logic        wb_a, wb_b, wb_rd;
  logic        raw_a, raw_b, waw;
  logic        rdy, accept, drain;

  assign rf_sel_a = bus.in_rs_a;
  assign rf_sel_b = bus.in_rs_b;

  always_comb begin
    wb_a = wb_we && (wb_addr == bus.in_rs_a);
    wb_b = wb_we && (wb_addr == bus.in_rs_b);
    wb_rd = wb_we && (wb_addr == bus.in_rd);

    opnd_a = rf_data_a;
    if (bus.in_rs_a == 5'd0) opnd_a = '0;
    else if (wb_a) opnd_a = wb_data;

    opnd_b = rf_data_b;
    if (bus.in_rs_b == 5'd0) opnd_b = '0;
    else if (wb_b) opnd_b = wb_data;

    // a write-back landing this cycle retires the writer
    raw_a = bus.in_use_a && (bus.in_rs_a != 5'd0)
         && busy_q[bus.in_rs_a] && !wb_a;
    raw_b = bus.in_use_b && (bus.in_rs_b != 5'd0)
         && busy_q[bus.in_rs_b] && !wb_b;
    waw = bus.in_rd_we && (bus.in_rd != 5'd0)
       && busy_q[bus.in_rd] && !wb_rd;

    rdy = !flush && !(raw_a || raw_b || waw)
       && (!out_valid_q || bus.out_ready);
    accept = bus.in_valid && rdy;
    drain = !accept
         && (flush || (out_valid_q && bus.out_ready));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    out_rd_d = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    out_ctrl_d = out_ctrl_q;
    unique case (1'b1)
      accept: begin
        out_valid_d = 1'b1;
        out_a_d = opnd_a;
        out_b_d = opnd_b;
        out_rd_d = bus.in_rd;
        out_rd_we_d = bus.in_rd_we;
        out_ctrl_d = bus.in_ctrl;
      end
      drain: out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    for (int n = 1; n < 32; n++) begin
      if (accept && bus.in_rd_we && (bus.in_rd == 5'(n)))
        busy_d[n] = 1'b1;
      else if (wb_we && (wb_addr == 5'(n)))
        busy_d[n] = 1'b0;
      else if (flush && out_valid_q && out_rd_we_q
               && (out_rd_q == 5'(n)))
        busy_d[n] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      out_valid_q <= 1'b0;
      out_a_q <= '0;
      out_b_q <= '0;
      out_rd_q <= '0;
      out_rd_we_q <= 1'b0;
      out_ctrl_q <= '0;
    end else begin
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      out_rd_q <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
      out_ctrl_q <= out_ctrl_d;
    end
  end

  assign bus.in_ready = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a = out_a_q;
  assign bus.out_b = out_b_q;
  assign bus.out_rd = out_rd_q;
  assign bus.out_rd_we = out_rd_we_q;
  assign bus.out_ctrl = out_ctrl_q;
  assign busy_map = busy_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vectors, expected
// results queued at accept and checked by a separate monitor.
module tb_operand_fetch_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic [15:0] ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rf_sel_a, rf_sel_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic [31:0] busy_map;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  operand_fetch_stage_if #(.CTRL_W(16)) bus ();

  operand_fetch_stage #(.CTRL_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .rf_sel_a(rf_sel_a),
    .rf_sel_b(rf_sel_b),
    .rf_data_a(rf_data_a),
    .rf_data_b(rf_data_b),
    .wb_we(wb_we),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .flush(flush),
    .busy_map(busy_map)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_rs_a = '0;
    bus.in_rs_b = '0;
    bus.in_use_a = 1'b0;
    bus.in_use_b = 1'b0;
    bus.in_rd = '0;
    bus.in_rd_we = 1'b0;
    bus.in_ctrl = '0;
    rf_data_a = '0;
    rf_data_b = '0;
    wb_we = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    flush = 1'b0;
  endtask

  task automatic present(input logic [4:0] ra, input logic ua,
                         input logic [4:0] rb, input logic ub,
                         input logic [4:0] rd, input logic we,
                         input logic [15:0] ctrl,
                         input logic [31:0] da, input logic [31:0] db);
    bus.in_valid = 1'b1;
    bus.in_rs_a = ra;
    bus.in_use_a = ua;
    bus.in_rs_b = rb;
    bus.in_use_b = ub;
    bus.in_rd = rd;
    bus.in_rd_we = we;
    bus.in_ctrl = ctrl;
    rf_data_a = da;
    rf_data_b = db;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input string nm,
                       input logic [4:0] ra, input logic ua,
                       input logic [4:0] rb, input logic ub,
                       input logic [4:0] rd, input logic we,
                       input logic [15:0] ctrl,
                       input logic [31:0] da, input logic [31:0] db,
                       input logic wbe, input logic [4:0] wba,
                       input logic [31:0] wbd,
                       input logic [31:0] ea, input logic [31:0] eb);
    bit ok;
    exp_t e;
    present(ra, ua, rb, ub, rd, we, ctrl, da, db);
    wb_we = wbe;
    wb_addr = wba;
    wb_data = wbd;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (!ok) tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_%s in_ready=0 expected=1 (timeout)", nm);
    end else begin
      e.a = ea;
      e.b = eb;
      e.rd = rd;
      e.we = we;
      e.ctrl = ctrl;
      exp_q.push_back(e);
    end
    tick();
    idle();
  endtask

  // Monitor: every output handshake pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected out_a=%h expected=none",
                   bus.out_a);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out_a", bus.out_a, e.a);
          chk("sb_out_b", bus.out_b, e.b);
          chk("sb_out_rd", 32'(bus.out_rd), 32'(e.rd));
          chk("sb_out_rd_we", 32'(bus.out_rd_we), 32'(e.we));
          chk("sb_out_ctrl", 32'(bus.out_ctrl), 32'(e.ctrl));
        end
      end
    end
  end

  initial begin
    exp_t drop;
    idle();
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", busy_map, 32'd0);
    chk("rst_out_a", bus.out_a, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // plain read; marks r1 busy
    issue("basic", 5'd3, 1, 5'd4, 1, 5'd1, 1, 16'hA001,
          32'h11, 32'h22, 0, 5'd0, 32'h0, 32'h11, 32'h22);
    chk("rf_sel_a", 32'(rf_sel_a), 32'd0);
    // $0 forcing, write-back to $0 ignored
    issue("zero", 5'd0, 1, 5'd6, 1, 5'd0, 1, 16'hA002,
          32'hDEADBEEF, 32'h66, 1, 5'd0, 32'h99, 32'h0, 32'h66);
    chk("busy_after_zero", busy_map, 32'h0000_0002);
    // same-cycle bypass on b
    issue("bypass", 5'd2, 1, 5'd5, 1, 5'd0, 0, 16'hA003,
          32'h2, 32'h1, 1, 5'd5, 32'h55, 32'h2, 32'h55);
    wb_we = 1'b1;
    wb_addr = 5'd1;
    tick();
    idle();
    @(negedge clk);
    chk("busy_r1_cleared", busy_map, 32'd0);
    tick();

    // RAW on r7
    issue("raw_prod", 5'd8, 1, 5'd0, 0, 5'd7, 1, 16'h0007,
          32'h8, 32'h0, 0, 5'd0, 32'h0, 32'h8, 32'h0);
    present(5'd7, 1, 5'd0, 0, 5'd10, 0, 16'h0002, 32'h700, 32'h0);
    @(negedge clk);
    chk("raw_stall_1", 32'(bus.in_ready), 32'd0);
    chk("raw_busy7", busy_map, 32'h0000_0080);
    tick();
    @(negedge clk);
    chk("raw_stall_2", 32'(bus.in_ready), 32'd0);
    tick();
    wb_we = 1'b1;
    wb_addr = 5'd7;
    wb_data = 32'h77;
    @(negedge clk);
    chk("raw_release", 32'(bus.in_ready), 32'd1);
    drop.a = 32'h77;
    drop.b = 32'h0;
    drop.rd = 5'd10;
    drop.we = 1'b0;
    drop.ctrl = 16'h0002;
    exp_q.push_back(drop);
    tick();
    idle();
    @(negedge clk);
    chk("raw_busy7_clr", busy_map, 32'd0);
    tick();

    // backpressure + WAW on r7
    bus.out_ready = 1'b0;
    issue("bp_x", 5'd3, 1, 5'd0, 0, 5'd7, 1, 16'h00B0,
          32'h33, 32'h0, 0, 5'd0, 32'h0, 32'h33, 32'h0);
    present(5'd0, 0, 5'd0, 0, 5'd7, 1, 16'h00C0, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_a", bus.out_a, 32'h33);
      chk("bp_out_ctrl", 32'(bus.out_ctrl), 32'h00B0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_busy7", busy_map, 32'h0000_0080);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("waw_stall", 32'(bus.in_ready), 32'd0);
    tick();
    wb_we = 1'b1;
    wb_addr = 5'd7;
    wb_data = 32'h700;
    @(negedge clk);
    chk("waw_release", 32'(bus.in_ready), 32'd1);
    drop.a = 32'h0;
    drop.b = 32'h0;
    drop.rd = 5'd7;
    drop.we = 1'b1;
    drop.ctrl = 16'h00C0;
    exp_q.push_back(drop);
    tick();
    idle();
    @(negedge clk);
    chk("waw_busy7_reset", busy_map, 32'h0000_0080);
    tick();
    wb_we = 1'b1;
    wb_addr = 5'd7;
    tick();
    idle();
    tick();

    // flush of held rd=9
    bus.out_ready = 1'b0;
    issue("flush_z", 5'd3, 1, 5'd0, 0, 5'd9, 1, 16'h0009,
          32'h33, 32'h0, 0, 5'd0, 32'h0, 32'h33, 32'h0);
    drop = exp_q.pop_back();
    present(5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h000F, 32'h0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    chk("flush_busy9_pre", busy_map, 32'h0000_0200);
    tick();
    idle();
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_busy9", busy_map, 32'd0);
    tick();

    // reset during a RAW stall with a held writer
    issue("rst_hold", 5'd0, 0, 5'd0, 0, 5'd12, 1, 16'h000E,
          32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    drop = exp_q.pop_back();
    present(5'd12, 1, 5'd0, 0, 5'd0, 0, 16'h0001, 32'h0, 32'h0);
    @(negedge clk);
    chk("pre_rst_stall", 32'(bus.in_ready), 32'd0);
    chk("pre_rst_busy", busy_map, 32'h0000_1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_busy", busy_map, 32'd0);
    chk("async_rst_rd", 32'(bus.out_rd), 32'd0);
    chk("async_rst_ctrl", 32'(bus.out_ctrl), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    issue("post_rst", 5'd3, 1, 5'd0, 0, 5'd0, 0, 16'h0011,
          32'h11, 32'h0, 0, 5'd0, 32'h0, 32'h11, 32'h0);
    tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-to-execute pipeline stage wrapped around the register-file read ports. Drives the two 5-bit read selects into the register file's 32:1 read muxes, captures the returned 32-bit operands with write-back bypass and $0 forcing, and holds them in a valid/ready output register for execute. A 32-entry scoreboard of in-flight writers stalls RAW and WAW hazards until write-back.

## Interface
- CTRL_W, 16, width of opaque control sideband passed through to execute
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs_a, in_rs_b  in  5  source register numbers
- in_use_a, in_use_b  in  1  source is actually read
- in_rd  in  5  destination register
- in_rd_we  in  1  instruction writes in_rd
- in_ctrl  in  CTRL_W  sideband
- rf_sel_a, rf_sel_b  out  5  register-file read selects
- rf_data_a, rf_data_b  in  32  register-file read data (combinational from selects)
- wb_we  in  1  write-back strobe
- wb_addr  in  5  write-back register
- wb_data  in  32  write-back data
- flush  in  1  kill the held instruction
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_a, out_b  out  32  resolved operands
- out_rd  out  5; out_rd_we  out  1; out_ctrl  out  CTRL_W  registered copies
- busy_map  out  32  scoreboard state (bit n = register n has an in-flight writer)

## Operation
- rf_sel_a = in_rs_a, rf_sel_b = in_rs_b, purely combinational.
- Operand resolve per source x: rs_x==0 -> 0; else wb_we && wb_addr==rs_x -> wb_data; else rf_data_x.
- wb_hit(n) = wb_we && wb_addr==n && n!=0.
- RAW hazard on x: in_use_x && rs_x!=0 && busy[rs_x] && !wb_hit(rs_x).
- WAW hazard: in_rd_we && in_rd!=0 && busy[in_rd] && !wb_hit(in_rd).
- hazard = RAW_a | RAW_b | WAW. in_ready = !flush && !hazard && (!out_valid || out_ready). in_ready may depend on in_* fields; never on in_valid.
- accept = in_valid && in_ready: output register loads resolved operands, in_rd, in_rd_we, in_ctrl; out_valid<=1.
- out_valid && out_ready && !accept: out_valid<=0. Otherwise output register holds.
- Scoreboard per bit n, per cycle, priority high->low: set if accept && in_rd_we && in_rd==n && n!=0; clear if wb_hit(n); clear if flush && out_valid && out_rd_we && out_rd==n; else hold. Bit 0 always 0.
- flush: out_valid<=0 next edge; killed instruction's busy bit cleared as above; wb clears still apply; no accept that cycle.
- Reset (async assert): out_valid, out_a, out_b, out_rd, out_rd_we, out_ctrl, busy_map all 0. Deassertion takes effect at the next rising edge; reset mid-stall discards held instruction and scoreboard.

## Timing
- Latency: 1 cycle accept -> out_valid. Throughput: 1 instruction/cycle when no hazard and out_ready=1.
- Bypass is same-cycle: a write-back in the accept cycle is visible in captured operand and lifts the hazard.
- Instruction accepted in cycle t marks busy from t+1; a dependent instruction in t+1 stalls until wb_hit for that register.
- While out_valid && !out_ready, all out_* are stable.
- busy_map registered; no combinational path from in_* to out_*.

## Test plan
- Reset: reset=0 with busy and out_valid set -> all outputs 0 immediately; after release, first instruction (rs_a=3, rf_data_a=0x11) gives out_a=0x11 one cycle later.
- $0 forcing: rs_a=0, rf_data_a=0xDEADBEEF, wb_we=1 wb_addr=0 -> out_a=0, busy_map[0]=0.
- Bypass: rs_b=5, rf_data_b=0x1, wb_we=1 wb_addr=5 wb_data=0x55 -> out_b=0x55.
- RAW stall: issue rd=7 we=1; next instr use_a rs_a=7 -> in_ready=0 until wb_addr=7 wb_data=0x77, accepted that cycle with out_a=0x77, busy_map[7]=0 (unless re-set by new rd=7).
- Backpressure/WAW: out_ready=0 two cycles -> out_* unchanged, in_ready=0; second rd=7 writer stalls while busy[7]=1.
- Flush: held instr rd=9 we=1, flush=1 -> out_valid=0, busy_map[9]=0 next cycle, in_ready=0 during flush.
